// File: rtl/mag_peak_pkg.sv
// ---------------------------------------------------------------------------
// mag_peak_pkg
//   Shared definitions for the per-frame magnitude peak detector:
//     - state_t   : control FSM states
//     - FLG_*     : bit positions inside the 3-bit result flags word
//     - sat_inc   : saturating increment used by the bin/above counters
// ---------------------------------------------------------------------------
package mag_peak_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int FLAG_W   = 3;
    localparam int FLG_OVF  = 0;
    localparam int FLG_SAT  = 1;
    localparam int FLG_DROP = 2;

    // The function works on a fixed 32-bit container; callers size-cast
    // their counters in and out. Counters wider than 32 bits are not supported.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end
        return val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/mag_peak_result_reg.sv
// ---------------------------------------------------------------------------
// mag_peak_result_reg
//   Valid/ready holding register for one frame result, with drop detection.
//
//   Handshake: a result transfers on a rising edge where tvalid & tready are
//   both high. While tvalid & !tready the payload holds stable. A new load
//   always wins: it overwrites the held payload and keeps tvalid high. If the
//   held result was still pending (tvalid & !tready) at that load, the bit
//   at DROP_POS of the new payload is set to report the loss.
//
//   Ports:
//     clk, aresetn : clock, async active-low reset
//     load         : new result available this cycle
//     load_data    : payload to capture on load
//     data         : held payload
//     tvalid       : payload valid
//     tready       : downstream accepts payload
//     drop         : combinational, this load overwrites an unaccepted result
// ---------------------------------------------------------------------------
module mag_peak_result_reg #(
    parameter int W        = 8,
    parameter int DROP_POS = 0
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         tvalid,
    input  logic         tready,
    output logic         drop
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign drop = load & valid_q & ~tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data | (drop ? (W'(1) << DROP_POS) : '0);
            valid_q <= 1'b1;
        end else if (valid_q && tready) begin
            valid_q <= 1'b0;
        end
    end

    assign data   = data_q;
    assign tvalid = valid_q;

endmodule

// File: rtl/mag_peak_detect.sv
// ---------------------------------------------------------------------------
// mag_peak_detect
//   Per-frame peak search on a squared-magnitude stream. For every frame
//   (terminated by mag_tlast) it reports the peak value, the bin of its first
//   occurrence, the number of samples strictly above a per-frame threshold,
//   the frame length and status flags through a valid/ready result register.
//
//   Ports:
//     clk, aresetn          : clock, async active-low reset
//     mag_tdata/overflow/
//     mag_tvalid/mag_tlast  : input sample stream (no backpressure)
//     threshold             : detection threshold, captured on first sample
//     peak_tdata            : peak of reported frame
//     peak_index            : bin of first peak occurrence
//     above_count           : samples > captured threshold (saturating)
//     frame_len             : samples in frame (saturating)
//     flags                 : [0] overflow seen, [1] length saturated,
//                             [2] previous result dropped
//     peak_tvalid/tready    : result handshake
//     dbg_state             : control FSM state
// ---------------------------------------------------------------------------
module mag_peak_detect
    import mag_peak_pkg::*;
#(
    parameter int DATA_LEN  = 64,
    parameter int INDEX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [DATA_LEN-1:0]  mag_tdata,
    input  logic                 mag_overflow,
    input  logic                 mag_tvalid,
    input  logic                 mag_tlast,
    input  logic [DATA_LEN-1:0]  threshold,
    output logic [DATA_LEN-1:0]  peak_tdata,
    output logic [INDEX_LEN-1:0] peak_index,
    output logic [INDEX_LEN-1:0] above_count,
    output logic [INDEX_LEN-1:0] frame_len,
    output logic [FLAG_W-1:0]    flags,
    output logic                 peak_tvalid,
    input  logic                 peak_tready,
    output state_t               dbg_state
);

    localparam logic [INDEX_LEN-1:0] IDX_MAX = '1;
    localparam int PAY_W    = DATA_LEN + 3 * INDEX_LEN + FLAG_W;
    localparam int DROP_POS = DATA_LEN + 3 * INDEX_LEN + FLG_DROP;

    state_t                state_q, state_n;
    logic [DATA_LEN-1:0]   peak_q, peak_n;
    logic [DATA_LEN-1:0]   thr_q, thr_n;
    logic [INDEX_LEN-1:0]  idx_q, idx_n;
    logic [INDEX_LEN-1:0]  cnt_q, cnt_n;
    logic [INDEX_LEN-1:0]  above_q, above_n;
    logic                  ovf_q, ovf_n;
    logic                  sat_q, sat_n;
    logic                  done;

    // An overflowed sample is treated as saturated for every comparison.
    logic [DATA_LEN-1:0]   eff;
    assign eff = mag_overflow ? '1 : mag_tdata;

    // ---------------- state / accumulator registers ----------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            peak_q  <= '0;
            thr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            above_q <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            peak_q  <= peak_n;
            thr_q   <= thr_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            above_q <= above_n;
            ovf_q   <= ovf_n;
            sat_q   <= sat_n;
        end
    end

    // ---------------- next-state / datapath ----------------
    // The *_n values are the frame totals including the current sample, so
    // on the tlast sample they are loaded straight into the result register.
    always_comb begin
        state_n = state_q;
        peak_n  = peak_q;
        thr_n   = thr_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        above_n = above_q;
        ovf_n   = ovf_q;
        sat_n   = sat_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mag_tvalid) begin
                    // First sample: compare against the live threshold input,
                    // which is also what gets captured for the rest of the frame.
                    peak_n  = eff;
                    idx_n   = '0;
                    cnt_n   = INDEX_LEN'(1);
                    above_n = (eff > threshold) ? INDEX_LEN'(1) : '0;
                    thr_n   = threshold;
                    ovf_n   = mag_overflow;
                    sat_n   = 1'b0;
                    if (mag_tlast) begin
                        done = 1'b1;
                    end else begin
                        state_n = ACC;
                    end
                end
            end

            ACC: begin
                if (mag_tvalid) begin
                    // cnt_q is the number of samples so far, i.e. this sample's bin.
                    if (eff > peak_q) begin
                        peak_n = eff;
                        idx_n  = cnt_q;
                    end
                    cnt_n = INDEX_LEN'(sat_inc(SAT_W'(cnt_q), SAT_W'(IDX_MAX)));
                    sat_n = sat_q | (cnt_q == IDX_MAX);
                    if (eff > thr_q) begin
                        above_n = INDEX_LEN'(sat_inc(SAT_W'(above_q), SAT_W'(IDX_MAX)));
                    end
                    ovf_n = ovf_q | mag_overflow;
                    if (mag_tlast) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ---------------- result register ----------------
    logic [FLAG_W-1:0] flg_n;
    always_comb begin
        flg_n          = '0;
        flg_n[FLG_OVF] = ovf_n;
        flg_n[FLG_SAT] = sat_n;
    end

    logic [PAY_W-1:0] pay_in, pay_out;
    logic             drop_unused;

    assign pay_in = {flg_n, cnt_n, above_n, idx_n, peak_n};

    mag_peak_result_reg #(
        .W        (PAY_W),
        .DROP_POS (DROP_POS)
    ) u_result (
        .clk       (clk),
        .aresetn   (aresetn),
        .load      (done),
        .load_data (pay_in),
        .data      (pay_out),
        .tvalid    (peak_tvalid),
        .tready    (peak_tready),
        .drop      (drop_unused)
    );

    assign {flags, frame_len, above_count, peak_index, peak_tdata} = pay_out;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mag_peak_detect.sv
module tb_mag_peak_detect;
  import mag_peak_pkg::*;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk;
  logic        aresetn;
  logic [63:0] mag_tdata;
  logic        mag_overflow;
  logic        mag_tvalid;
  logic        mag_tlast;
  logic [63:0] threshold;
  logic        peak_tready;

  // main instance (INDEX_LEN 16)
  logic [63:0] peak_tdata;
  logic [15:0] peak_index, above_count, frame_len;
  logic [2:0]  flags;
  logic        peak_tvalid;
  state_t      dbg_state;

  // narrow-counter instance (INDEX_LEN 4) for saturation
  logic [63:0] s_peak_tdata;
  logic [3:0]  s_peak_index, s_above_count, s_frame_len;
  logic [2:0]  s_flags;
  logic        s_peak_tvalid;
  state_t      s_dbg_state;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mag_peak_detect #(.DATA_LEN(64), .INDEX_LEN(16)) dut (
    .clk(clk), .aresetn(aresetn),
    .mag_tdata(mag_tdata), .mag_overflow(mag_overflow),
    .mag_tvalid(mag_tvalid), .mag_tlast(mag_tlast),
    .threshold(threshold),
    .peak_tdata(peak_tdata), .peak_index(peak_index),
    .above_count(above_count), .frame_len(frame_len), .flags(flags),
    .peak_tvalid(peak_tvalid), .peak_tready(peak_tready),
    .dbg_state(dbg_state)
  );

  mag_peak_detect #(.DATA_LEN(64), .INDEX_LEN(4)) dut_sat (
    .clk(clk), .aresetn(aresetn),
    .mag_tdata(mag_tdata), .mag_overflow(mag_overflow),
    .mag_tvalid(mag_tvalid), .mag_tlast(mag_tlast),
    .threshold(threshold),
    .peak_tdata(s_peak_tdata), .peak_index(s_peak_index),
    .above_count(s_above_count), .frame_len(s_frame_len), .flags(s_flags),
    .peak_tvalid(s_peak_tvalid), .peak_tready(peak_tready),
    .dbg_state(s_dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [63:0] pk, input int idx,
                           input int cnt, input int len, input logic [2:0] fl);
    check({tag, "_vld"},   64'(peak_tvalid), 64'd1);
    check({tag, "_peak"},  peak_tdata, pk);
    check({tag, "_idx"},   64'(peak_index), 64'(idx));
    check({tag, "_above"}, 64'(above_count), 64'(cnt));
    check({tag, "_len"},   64'(frame_len), 64'(len));
    check({tag, "_flags"}, 64'(flags), 64'(fl));
  endtask

  // ---------------- driver tasks ----------------
  // Each call presents one valid sample for exactly one clock edge and
  // returns 1 time unit after that edge.
  task automatic send(input logic [63:0] d, input logic ovf, input logic last);
    mag_tdata    = d;
    mag_overflow = ovf;
    mag_tvalid   = 1'b1;
    mag_tlast    = last;
    @(posedge clk);
    #1;
    mag_tvalid   = 1'b0;
    mag_tlast    = 1'b0;
    mag_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input string tag);
    peak_tready = 1'b1;
    @(posedge clk);
    #1;
    peak_tready = 1'b0;
    check({tag, "_acc_vld"}, 64'(peak_tvalid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    aresetn      = 1'b0;
    mag_tdata    = '0;
    mag_overflow = 1'b0;
    mag_tvalid   = 1'b0;
    mag_tlast    = 1'b0;
    threshold    = '0;
    peak_tready  = 1'b0;

    idle(3);
    check("rst_vld",   64'(peak_tvalid), 64'd0);
    check("rst_peak",  peak_tdata, 64'd0);
    check("rst_idx",   64'(peak_index), 64'd0);
    check("rst_above", 64'(above_count), 64'd0);
    check("rst_len",   64'(frame_len), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    aresetn = 1'b1;
    idle(2);

    // basic frame {5,9,3,9,1}, threshold 4
    threshold = 64'd4;
    send(64'd5, 1'b0, 1'b0);
    check("basic_state_acc", 64'(dbg_state), 64'(ACC));
    send(64'd9, 1'b0, 1'b0);
    send(64'd3, 1'b0, 1'b0);
    send(64'd9, 1'b0, 1'b0);
    check("basic_vld_early", 64'(peak_tvalid), 64'd0);
    send(64'd1, 1'b0, 1'b1);
    check_res("basic", 64'd9, 1, 3, 5, 3'b000);
    check("basic_state_idle", 64'(dbg_state), 64'(IDLE));
    accept("basic");

    // single-sample frame {7}, threshold 7 (equal is not above)
    threshold = 64'd7;
    send(64'd7, 1'b0, 1'b1);
    check_res("single", 64'd7, 0, 0, 1, 3'b000);
    accept("single");

    // gappy frame {2, gap x3, 8}
    send(64'd2, 1'b0, 1'b0);
    idle(3);
    check("gap_vld", 64'(peak_tvalid), 64'd0);
    send(64'd8, 1'b0, 1'b1);
    check_res("gap", 64'd8, 1, 1, 2, 3'b000);
    accept("gap");

    // overflow mid-frame {20, 10+ovf, 30}, threshold 15 then changed mid-frame
    threshold = 64'd15;
    send(64'd20, 1'b0, 1'b0);
    threshold = 64'd100;
    send(64'd10, 1'b1, 1'b0);
    send(64'd30, 1'b0, 1'b1);
    check_res("ovf", 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, 3, 3'b001);
    accept("ovf");

    // backpressure: two back-to-back frames, second overwrites first
    threshold = 64'd0;
    send(64'd1, 1'b0, 1'b0);
    send(64'd2, 1'b0, 1'b1);
    check_res("bp_first", 64'd2, 1, 2, 2, 3'b000);
    send(64'd3, 1'b0, 1'b1);
    check_res("bp_drop", 64'd3, 0, 1, 1, 3'b100);
    idle(2);
    check_res("bp_hold", 64'd3, 0, 1, 1, 3'b100);
    accept("bp");

    // same, but the first result is accepted on the second tlast edge
    send(64'd1, 1'b0, 1'b0);
    send(64'd2, 1'b0, 1'b1);
    check_res("hs_first", 64'd2, 1, 2, 2, 3'b000);
    peak_tready = 1'b1;
    send(64'd3, 1'b0, 1'b1);
    peak_tready = 1'b0;
    check_res("hs_nodrop", 64'd3, 0, 1, 1, 3'b000);
    accept("hs");

    // saturation: 20 samples of 100, threshold 0
    threshold = 64'd0;
    for (int i = 0; i < 20; i++) begin
      send(64'd100, 1'b0, (i == 19));
    end
    check_res("wide20", 64'd100, 0, 20, 20, 3'b000);
    check("sat_vld",   64'(s_peak_tvalid), 64'd1);
    check("sat_peak",  s_peak_tdata, 64'd100);
    check("sat_idx",   64'(s_peak_index), 64'd0);
    check("sat_above", 64'(s_above_count), 64'd15);
    check("sat_len",   64'(s_frame_len), 64'd15);
    check("sat_flags", 64'(s_flags), 64'(3'b010));
    check("sat_state", 64'(s_dbg_state), 64'(IDLE));
    accept("sat");

    // leave an unaccepted result pending, then reset in the middle of a frame
    threshold = 64'd0;
    send(64'd50, 1'b0, 1'b1);
    check_res("pre_rst", 64'd50, 0, 1, 1, 3'b000);
    send(64'd1, 1'b0, 1'b0);
    send(64'd2, 1'b0, 1'b0);
    mag_tdata  = 64'd3;
    mag_tvalid = 1'b1;
    #3;
    aresetn = 1'b0;
    #1;
    check("mrst_vld",   64'(peak_tvalid), 64'd0);
    check("mrst_peak",  peak_tdata, 64'd0);
    check("mrst_len",   64'(frame_len), 64'd0);
    check("mrst_state", 64'(dbg_state), 64'(IDLE));
    mag_tvalid = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(3);
    check("mrst_noresult", 64'(peak_tvalid), 64'd0);

    threshold = 64'd5;
    send(64'd4, 1'b0, 1'b0);
    send(64'd6, 1'b0, 1'b1);
    check_res("post_rst", 64'd6, 1, 1, 2, 3'b000);
    accept("post_rst");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_peak_detect.md
# mag_peak_detect

- Per-pulse peak search on the squared-magnitude stream from `sq_mag_estimate`, one frame per radar range line.
- Per frame it reports the largest sample, its range-bin index, the count of samples above a threshold, and the frame length.
- Sits directly downstream of the magnitude stage and feeds the host/telemetry packetizer through a valid/ready result register.

## Interface
Parameters:
- `DATA_LEN`, 64 — width of the magnitude sample; equals 2× the I/Q width upstream.
- `INDEX_LEN`, 16 — width of bin index, above-threshold count and frame length counters.

Ports:
- `clk`  in  1  — single clock for the block.
- `aresetn`  in  1  — reset, asynchronous assert and active-low; deasserted synchronously to `clk` by the top level.
- `mag_tdata`  in  DATA_LEN  — squared magnitude sample.
- `mag_overflow`  in  1  — upstream overflow bit, qualified by `mag_tvalid`.
- `mag_tvalid`  in  1  — sample valid. There is no ready: the block accepts every valid sample.
- `mag_tlast`  in  1  — last sample of the frame.
- `threshold`  in  DATA_LEN  — detection threshold, captured on the first sample of each frame.
- `peak_tdata`  out  DATA_LEN  — peak value of the reported frame.
- `peak_index`  out  INDEX_LEN  — bin of the first occurrence of the peak.
- `above_count`  out  INDEX_LEN  — number of samples strictly greater than the threshold.
- `frame_len`  out  INDEX_LEN  — number of samples in the frame.
- `flags`  out  3  — bit 0: overflow seen in frame; bit 1: length saturated; bit 2: previous result dropped.
- `peak_tvalid`  out  1  — result valid.
- `peak_tready`  in  1  — result accepted.

## Operation
- **Control FSM**, states IDLE and ACC.
  - IDLE: a valid sample starts a frame. That sample initialises the running peak, sets index 0, sets count to 1, and captures `threshold`.
    - If `mag_tlast` is also high, the frame completes immediately (single-sample frame).
    - Otherwise the FSM goes to ACC.
  - ACC: each valid sample increments the bin counter, so the first sample is bin 0.
    - If sample > running peak (strict), the running peak and index update; ties keep the earlier bin.
    - A valid sample with `mag_tlast` completes the frame and the FSM returns to IDLE.
  - Cycles with `mag_tvalid` low are ignored in both states.
- **Overflow:**
  - A sample with `mag_overflow` = 1 is treated as all-ones (saturated) for both the peak and threshold comparisons.
  - It also sets the frame's flag bit 0.
- **Threshold:** `above_count` increments when the effective sample > captured threshold.
- **Counter saturation:** the bin counter and `above_count` saturate at 2^INDEX_LEN−1. Saturation of the bin counter sets flag bit 1, and `frame_len` then reads 2^INDEX_LEN−1.
- **Frame completion:**
  - Peak, index, count, length and flags are loaded into the output register and `peak_tvalid` is set.
  - If `peak_tvalid` was already high and not being accepted that cycle, the old result is overwritten and flag bit 2 of the new result is set.
  - If the old result is accepted in the same cycle (`peak_tvalid & peak_tready`), no drop is flagged and `peak_tvalid` stays 1.
- **Output register:** holds stable while `peak_tvalid & !peak_tready`. It clears `peak_tvalid` on handshake unless a new result loads in that cycle.

## Timing
- **Reset:**
  - FSM to IDLE; all accumulators cleared.
  - Outputs reset values: `peak_tvalid` = 0, `peak_tdata` = 0, `peak_index` = 0, `above_count` = 0, `frame_len` = 0, `flags` = 0.
  - A reset mid-frame discards the partial frame; no result is produced for it.
- **Latency:** the result is visible with `peak_tvalid` = 1 on the first rising edge after the `mag_tlast` sample is sampled (1 cycle).
- **Throughput:** back-to-back frames with zero idle cycles are supported. A new frame's first sample may arrive the cycle after `mag_tlast`.
- **Threshold capture:** `threshold` changes mid-frame take effect from the next frame.
- **Comparisons:** all unsigned, at full DATA_LEN width.

## Structure
- Package `mag_peak_pkg`:
  - FSM state enum (IDLE, ACC).
  - Flag bit-position constants `FLG_OVF` = 0, `FLG_SAT` = 1, `FLG_DROP` = 2.
  - Saturating-increment function.
- One sub-module: `mag_peak_result_reg`, the valid/ready output holding register with drop detection. It is parameterised by payload width and instantiated once. The search datapath stays in the top level.

## Test plan
- **Basic frame:** frame {5, 9, 3, 9, 1} with `tlast` on 1, threshold 4, no gaps -> one cycle after `tlast`: peak 9, index 1, `above_count` 3, `frame_len` 5, flags 0.
- **Single sample, gappy frames:**
  - Single-sample frame {7} with `tvalid` & `tlast` together in IDLE, threshold 7 -> peak 7, index 0, count 0, len 1.
  - Then a frame {2, –gap–, 8} with `tvalid` low for 3 cycles mid-frame -> peak 8, index 1, len 2.
- **Overflow:** sample 10 with `mag_overflow` = 1 mid-frame among {20, 30} -> peak all-ones, index 1, flags = 3'b001, count 3 with threshold 15.
- **Backpressure:**
  - `peak_tready` = 0; two back-to-back frames -> second result overwrites the first, flags bit 2 = 1, `peak_tvalid` held.
  - Repeat with `tready` = 1 on the second `tlast` edge -> no drop flag, `tvalid` continuous.
- **Saturation:** INDEX_LEN = 4, 20-sample frame of all 100s, threshold 0 -> `frame_len` 15, `above_count` 15, index 0, flags bit 1 = 1.
- **Reset mid-frame:** assert `aresetn` = 0 asynchronously mid-cycle during sample 3 of a 6-sample frame -> outputs zero immediately, no result. The next full frame {4, 6} reports peak 6, index 1, len 2.
